// File: rtl/axil_mitm_wr.sv
// axil_mitm_wr -- AXI4-Lite write-channel man-in-the-middle register stage.
//
// Collects one AW and one W beat from the slave port (in any order or together),
// forwards both to the master port, waits for the master B response and returns
// it on the slave port. At most one write is in flight. Every output is a flop.
//
// Ports
//   clk, rst            clock (rising edge); synchronous active-high reset
//   s_axil_aw*/w*/b*    upstream write channels (this block is the subordinate)
//   m_axil_aw*/w*/b*    downstream write channels (this block is the manager)
//
// Reset clears the control flops (state, capture flags, all valid/ready outputs).
// Payload flops (address, prot, data, strobe, bresp) start at zero and ignore rst.

module axil_mitm_wr #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready
);

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } state_t;

  state_t state_q, state_d;

  logic aw_done_q, aw_done_d;
  logic w_done_q,  w_done_d;

  logic s_awready_q, s_awready_d;
  logic s_wready_q,  s_wready_d;
  logic s_bvalid_q,  s_bvalid_d;
  logic m_awvalid_q, m_awvalid_d;
  logic m_wvalid_q,  m_wvalid_d;
  logic m_bready_q,  m_bready_d;

  logic [ADDR_WIDTH-1:0] m_awaddr_q = '0;
  logic [ADDR_WIDTH-1:0] m_awaddr_d;
  logic [2:0]            m_awprot_q = '0;
  logic [2:0]            m_awprot_d;
  logic [DATA_WIDTH-1:0] m_wdata_q  = '0;
  logic [DATA_WIDTH-1:0] m_wdata_d;
  logic [STRB_WIDTH-1:0] m_wstrb_q  = '0;
  logic [STRB_WIDTH-1:0] m_wstrb_d;
  logic [1:0]            s_bresp_q  = '0;
  logic [1:0]            s_bresp_d;

  logic aw_hs, w_hs, b_hs;

  assign aw_hs = s_axil_awvalid && s_awready_q;
  assign w_hs  = s_axil_wvalid  && s_wready_q;
  assign b_hs  = m_axil_bvalid  && m_bready_q;

  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    s_awready_d = s_awready_q;
    s_wready_d  = s_wready_q;
    s_bvalid_d  = s_bvalid_q;
    m_awvalid_d = m_awvalid_q;
    m_wvalid_d  = m_wvalid_q;
    m_bready_d  = m_bready_q;
    m_awaddr_d  = m_awaddr_q;
    m_awprot_d  = m_awprot_q;
    m_wdata_d   = m_wdata_q;
    m_wstrb_d   = m_wstrb_q;
    s_bresp_d   = s_bresp_q;

    // Master AW/W and slave B drain on their own handshakes in either state.
    if (m_awvalid_q && m_axil_awready) m_awvalid_d = 1'b0;
    if (m_wvalid_q  && m_axil_wready)  m_wvalid_d  = 1'b0;
    if (s_bvalid_q  && s_axil_bready)  s_bvalid_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        m_bready_d = 1'b0;
        if (aw_hs) begin
          m_awaddr_d = s_axil_awaddr;
          m_awprot_d = s_axil_awprot;
          aw_done_d  = 1'b1;
        end
        if (w_hs) begin
          m_wdata_d = s_axil_wdata;
          m_wstrb_d = s_axil_wstrb;
          w_done_d  = 1'b1;
        end
        // Readies are computed from next-state flags so they drop right after
        // their own handshake rather than one cycle late.
        if (aw_done_d && w_done_d) begin
          m_awvalid_d = 1'b1;
          m_wvalid_d  = 1'b1;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          s_awready_d = 1'b0;
          s_wready_d  = 1'b0;
          // A still-pending slave response must not be overwritten by a new B.
          m_bready_d  = !m_axil_bvalid && !s_bvalid_d;
          state_d     = ST_RESP;
        end else begin
          s_awready_d = !m_awvalid_d && !aw_done_d;
          s_wready_d  = !m_wvalid_d  && !w_done_d;
        end
      end

      ST_RESP: begin
        s_awready_d = 1'b0;
        s_wready_d  = 1'b0;
        if (b_hs) begin
          s_bresp_d   = m_axil_bresp;
          s_bvalid_d  = 1'b1;
          m_bready_d  = 1'b0;
          s_awready_d = !m_awvalid_d;
          s_wready_d  = !m_wvalid_d;
          state_d     = ST_IDLE;
        end else begin
          m_bready_d = !s_bvalid_d;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      s_awready_q <= 1'b0;
      s_wready_q  <= 1'b0;
      s_bvalid_q  <= 1'b0;
      m_awvalid_q <= 1'b0;
      m_wvalid_q  <= 1'b0;
      m_bready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      s_awready_q <= s_awready_d;
      s_wready_q  <= s_wready_d;
      s_bvalid_q  <= s_bvalid_d;
      m_awvalid_q <= m_awvalid_d;
      m_wvalid_q  <= m_wvalid_d;
      m_bready_q  <= m_bready_d;
    end
  end

  always_ff @(posedge clk) begin
    m_awaddr_q <= m_awaddr_d;
    m_awprot_q <= m_awprot_d;
    m_wdata_q  <= m_wdata_d;
    m_wstrb_q  <= m_wstrb_d;
    s_bresp_q  <= s_bresp_d;
  end

  assign s_axil_awready = s_awready_q;
  assign s_axil_wready  = s_wready_q;
  assign s_axil_bvalid  = s_bvalid_q;
  assign s_axil_bresp   = s_bresp_q;
  assign m_axil_awaddr  = m_awaddr_q;
  assign m_axil_awprot  = m_awprot_q;
  assign m_axil_awvalid = m_awvalid_q;
  assign m_axil_wdata   = m_wdata_q;
  assign m_axil_wstrb   = m_wstrb_q;
  assign m_axil_wvalid  = m_wvalid_q;
  assign m_axil_bready  = m_bready_q;

endmodule

// File: tb/tb_axil_mitm_wr.sv
// Testbench for axil_mitm_wr: directed scenarios with cycle-exact expectations,
// then randomized traffic checked against a transaction-order reference model.
module tb_axil_mitm_wr;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int RN = 40;
  localparam int TMO = 300;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] s_axil_awaddr;
  logic [2:0]    s_axil_awprot;
  logic          s_axil_awvalid, s_axil_awready;
  logic [DW-1:0] s_axil_wdata;
  logic [SW-1:0] s_axil_wstrb;
  logic          s_axil_wvalid, s_axil_wready;
  logic [1:0]    s_axil_bresp;
  logic          s_axil_bvalid, s_axil_bready;
  logic [AW-1:0] m_axil_awaddr;
  logic [2:0]    m_axil_awprot;
  logic          m_axil_awvalid, m_axil_awready;
  logic [DW-1:0] m_axil_wdata;
  logic [SW-1:0] m_axil_wstrb;
  logic          m_axil_wvalid, m_axil_wready;
  logic [1:0]    m_axil_bresp;
  logic          m_axil_bvalid, m_axil_bready;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: transaction table, in issue order
  logic [AW-1:0] ta [RN];
  logic [2:0]    tp [RN];
  logic [DW-1:0] td [RN];
  logic [SW-1:0] ts [RN];
  logic [1:0]    tb [RN];
  int maw_cnt, mw_cnt, mb_cnt;
  bit abort;

  always #5 clk = ~clk;

  axil_mitm_wr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready)
  );

  // Protocol monitor: sampled 1ns after the falling edge, where inputs for the
  // coming rising edge are already applied and registered outputs are settled.
  logic p_ok = 1'b0;
  logic p_sbv, p_sbr, p_mav, p_mar, p_mwv, p_mwr;
  logic [1:0] p_bresp;
  logic [AW-1:0] p_addr;
  logic [2:0] p_prot;
  logic [DW-1:0] p_data;
  logic [SW-1:0] p_strb;

  always begin
    @(negedge clk);
    #1;
    if (rst !== 1'b0) begin
      p_ok = 1'b0;
    end else begin
      n_checks++;
      if (m_axil_bready && s_axil_bvalid) begin
        n_fail++; $display("FAIL mon_bready_overlap: m_bready=%b while s_bvalid=%b, required m_bready=0", m_axil_bready, s_axil_bvalid);
      end
      if (p_ok && p_sbv && !p_sbr) begin
        n_checks++;
        if ({s_axil_bvalid, s_axil_bresp} !== {1'b1, p_bresp}) begin
          n_fail++; $display("FAIL mon_b_hold: got valid=%b resp=%0d, required valid=1 resp=%0d", s_axil_bvalid, s_axil_bresp, p_bresp);
        end
      end
      if (p_ok && p_mav && !p_mar) begin
        n_checks++;
        if ({m_axil_awvalid, m_axil_awaddr, m_axil_awprot} !== {1'b1, p_addr, p_prot}) begin
          n_fail++; $display("FAIL mon_aw_hold: got valid=%b addr=%h, required valid=1 addr=%h", m_axil_awvalid, m_axil_awaddr, p_addr);
        end
      end
      if (p_ok && p_mwv && !p_mwr) begin
        n_checks++;
        if ({m_axil_wvalid, m_axil_wdata, m_axil_wstrb} !== {1'b1, p_data, p_strb}) begin
          n_fail++; $display("FAIL mon_w_hold: got valid=%b data=%h, required valid=1 data=%h", m_axil_wvalid, m_axil_wdata, p_data);
        end
      end
      p_ok = 1'b1;
      p_sbv = s_axil_bvalid; p_sbr = s_axil_bready; p_bresp = s_axil_bresp;
      p_mav = m_axil_awvalid; p_mar = m_axil_awready; p_addr = m_axil_awaddr; p_prot = m_axil_awprot;
      p_mwv = m_axil_wvalid; p_mwr = m_axil_wready; p_data = m_axil_wdata; p_strb = m_axil_wstrb;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    s_axil_awaddr = '0; s_axil_awprot = '0; s_axil_awvalid = 1'b0;
    s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0;
    s_axil_bready = 1'b0;
    m_axil_awready = 1'b0; m_axil_wready = 1'b0;
    m_axil_bresp = '0; m_axil_bvalid = 1'b0;
  endtask

  task automatic send_aw_w(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    s_axil_awaddr = a; s_axil_awprot = 3'd0; s_axil_awvalid = 1'b1;
    s_axil_wdata = d; s_axil_wstrb = s; s_axil_wvalid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) tick();
    n_checks++;
    if ({s_axil_awready, s_axil_wready, s_axil_bvalid, m_axil_awvalid, m_axil_wvalid, m_axil_bready} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b, required 000000", {s_axil_awready, s_axil_wready, s_axil_bvalid, m_axil_awvalid, m_axil_wvalid, m_axil_bready});
    end
    n_checks++;
    if ({m_axil_awaddr, m_axil_wdata, m_axil_wstrb, s_axil_bresp} !== '0) begin
      n_fail++; $display("FAIL reset_payload: got addr=%h data=%h strb=%h resp=%0d, required all 0", m_axil_awaddr, m_axil_wdata, m_axil_wstrb, s_axil_bresp);
    end
    rst = 1'b0;
    n_checks++;
    if ({s_axil_awready, s_axil_wready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_first_cycle_ready: got %b, required 00", {s_axil_awready, s_axil_wready});
    end
    tick();
    n_checks++;
    if ({s_axil_awready, s_axil_wready} !== 2'b11) begin
      n_fail++; $display("FAIL reset_ready_rise: got %b, required 11", {s_axil_awready, s_axil_wready});
    end
  endtask

  task automatic test_same_cycle();
    m_axil_awready = 1'b1; m_axil_wready = 1'b1;
    send_aw_w(32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    n_checks++;
    if ({m_axil_awvalid, m_axil_wvalid, m_axil_awaddr, m_axil_wdata, m_axil_wstrb} !== {2'b11, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF}) begin
      n_fail++; $display("FAIL same_fwd: got v=%b%b addr=%h data=%h strb=%h, required v=11 addr=00001000 data=deadbeef strb=f",
                         m_axil_awvalid, m_axil_wvalid, m_axil_awaddr, m_axil_wdata, m_axil_wstrb);
    end
    n_checks++;
    if ({s_axil_awready, s_axil_wready} !== 2'b00) begin
      n_fail++; $display("FAIL same_slave_ready_drop: got %b, required 00", {s_axil_awready, s_axil_wready});
    end
    tick();
    n_checks++;
    if ({m_axil_awvalid, m_axil_wvalid, m_axil_bready} !== 3'b001) begin
      n_fail++; $display("FAIL same_master_accept: got awv/wv/bready=%b, required 001", {m_axil_awvalid, m_axil_wvalid, m_axil_bready});
    end
    m_axil_bvalid = 1'b1; m_axil_bresp = 2'b00;
    tick();
    m_axil_bvalid = 1'b0;
    n_checks++;
    if ({s_axil_bvalid, s_axil_bresp, m_axil_bready, s_axil_awready} !== {1'b1, 2'b00, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL same_bresp: got bvalid=%b bresp=%0d m_bready=%b awready=%b, required 1 0 0 1",
                         s_axil_bvalid, s_axil_bresp, m_axil_bready, s_axil_awready);
    end
    s_axil_bready = 1'b1;
    tick();
    s_axil_bready = 1'b0;
    n_checks++;
    if (s_axil_bvalid !== 1'b0) begin
      n_fail++; $display("FAIL same_bvalid_fall: got %b, required 0", s_axil_bvalid);
    end
    idle_inputs();
  endtask

  task automatic test_w_first();
    m_axil_awready = 1'b1; m_axil_wready = 1'b1;
    s_axil_awaddr = 32'h0000_2004; s_axil_wdata = 32'h1234_5678; s_axil_wstrb = 4'hF;
    for (int c = 0; c < 10; c++) begin
      s_axil_wvalid  = (c == 2);
      s_axil_awvalid = (c == 6);
      n_checks++;
      if ({s_axil_wready, s_axil_awready} !== {c <= 2, c <= 6}) begin
        n_fail++; $display("FAIL wfirst_ready c=%0d: got wready/awready=%b%b, required %b%b", c, s_axil_wready, s_axil_awready, c <= 2, c <= 6);
      end
      n_checks++;
      if ({m_axil_awvalid, m_axil_wvalid} !== {c == 7, c == 7}) begin
        n_fail++; $display("FAIL wfirst_mvalid c=%0d: got %b%b, required %b%b", c, m_axil_awvalid, m_axil_wvalid, c == 7, c == 7);
      end
      if (c == 7) begin
        n_checks++;
        if ({m_axil_awaddr, m_axil_wdata} !== {32'h0000_2004, 32'h1234_5678}) begin
          n_fail++; $display("FAIL wfirst_payload: got addr=%h data=%h, required 00002004 12345678", m_axil_awaddr, m_axil_wdata);
        end
      end
      tick();
    end
    m_axil_bvalid = 1'b1; m_axil_bresp = 2'b01;
    tick();
    m_axil_bvalid = 1'b0;
    n_checks++;
    if ({s_axil_bvalid, s_axil_bresp} !== 3'b101) begin
      n_fail++; $display("FAIL wfirst_bresp: got valid=%b resp=%0d, required 1 1", s_axil_bvalid, s_axil_bresp);
    end
    s_axil_bready = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_master_skew();
    send_aw_w(32'h0000_3008, 32'hA5A5_5A5A, 4'h3);
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      m_axil_awready = 1'b1;
      m_axil_wready  = (k >= 3);
      n_checks++;
      if ({m_axil_awvalid, m_axil_wvalid} !== {k == 0, k <= 3}) begin
        n_fail++; $display("FAIL skew_valid k=%0d: got aw/w=%b%b, required %b%b", k, m_axil_awvalid, m_axil_wvalid, k == 0, k <= 3);
      end
      if (k <= 3) begin
        n_checks++;
        if ({m_axil_wdata, m_axil_wstrb} !== {32'hA5A5_5A5A, 4'h3}) begin
          n_fail++; $display("FAIL skew_wdata k=%0d: got %h/%h, required a5a55a5a/3", k, m_axil_wdata, m_axil_wstrb);
        end
      end
      tick();
    end
    m_axil_awready = 1'b0; m_axil_wready = 1'b0;
    m_axil_bvalid = 1'b1; m_axil_bresp = 2'b11;
    tick();
    m_axil_bvalid = 1'b0;
    n_checks++;
    if ({s_axil_bvalid, s_axil_bresp} !== 3'b111) begin
      n_fail++; $display("FAIL skew_bresp: got valid=%b resp=%0d, required 1 3", s_axil_bvalid, s_axil_bresp);
    end
    s_axil_bready = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_b_backpressure();
    m_axil_awready = 1'b1; m_axil_wready = 1'b1;
    send_aw_w(32'h0000_4000, 32'h1111_2222, 4'hF);
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    tick();
    m_axil_bvalid = 1'b1; m_axil_bresp = 2'b10;
    tick();
    m_axil_bvalid = 1'b0;
    n_checks++;
    if ({s_axil_bvalid, s_axil_bresp, s_axil_awready} !== 4'b1101) begin
      n_fail++; $display("FAIL bp_first_resp: got valid=%b resp=%0d awready=%b, required 1 2 1", s_axil_bvalid, s_axil_bresp, s_axil_awready);
    end
    send_aw_w(32'h0000_4004, 32'h3333_4444, 4'h5);
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    n_checks++;
    if ({m_axil_awvalid, m_axil_awaddr, m_axil_bready} !== {1'b1, 32'h0000_4004, 1'b0}) begin
      n_fail++; $display("FAIL bp_second_fwd: got awv=%b addr=%h m_bready=%b, required 1 00004004 0", m_axil_awvalid, m_axil_awaddr, m_axil_bready);
    end
    m_axil_bvalid = 1'b1; m_axil_bresp = 2'b01;
    for (int j = 0; j < 4; j++) begin
      tick();
      n_checks++;
      if ({m_axil_bready, s_axil_bvalid, s_axil_bresp} !== 4'b0110) begin
        n_fail++; $display("FAIL bp_hold j=%0d: got m_bready=%b s_bvalid=%b resp=%0d, required 0 1 2", j, m_axil_bready, s_axil_bvalid, s_axil_bresp);
      end
    end
    s_axil_bready = 1'b1;
    tick();
    s_axil_bready = 1'b0;
    n_checks++;
    if ({s_axil_bvalid, m_axil_bready} !== 2'b01) begin
      n_fail++; $display("FAIL bp_release: got s_bvalid=%b m_bready=%b, required 0 1", s_axil_bvalid, m_axil_bready);
    end
    tick();
    m_axil_bvalid = 1'b0;
    n_checks++;
    if ({s_axil_bvalid, s_axil_bresp} !== 3'b101) begin
      n_fail++; $display("FAIL bp_second_resp: got valid=%b resp=%0d, required 1 1", s_axil_bvalid, s_axil_bresp);
    end
    s_axil_bready = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    send_aw_w(32'h0000_5550, 32'h55AA_55AA, 4'hF);
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    n_checks++;
    if (m_axil_awvalid !== 1'b1) begin
      n_fail++; $display("FAIL rmid_pre: got m_awvalid=%b, required 1", m_axil_awvalid);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({s_axil_awready, s_axil_wready, s_axil_bvalid, m_axil_awvalid, m_axil_wvalid, m_axil_bready} !== 6'b0) begin
      n_fail++; $display("FAIL rmid_ctrl: got %b, required 000000", {s_axil_awready, s_axil_wready, s_axil_bvalid, m_axil_awvalid, m_axil_wvalid, m_axil_bready});
    end
    n_checks++;
    if ({m_axil_awaddr, m_axil_wdata} !== {32'h0000_5550, 32'h55AA_55AA}) begin
      n_fail++; $display("FAIL rmid_payload_kept: got addr=%h data=%h, required 00005550 55aa55aa", m_axil_awaddr, m_axil_wdata);
    end
    rst = 1'b0;
    n_checks++;
    if (s_axil_awready !== 1'b0) begin
      n_fail++; $display("FAIL rmid_first_cycle: got awready=%b, required 0", s_axil_awready);
    end
    for (int j = 0; j < 3; j++) begin
      tick();
      n_checks++;
      if ({s_axil_awready, s_axil_wready, m_axil_awvalid, m_axil_wvalid, s_axil_bvalid} !== 5'b11000) begin
        n_fail++; $display("FAIL rmid_after j=%0d: got %b, required 11000", j, {s_axil_awready, s_axil_wready, m_axil_awvalid, m_axil_wvalid, s_axil_bvalid});
      end
    end
    m_axil_awready = 1'b1; m_axil_wready = 1'b1;
    send_aw_w(32'h0000_6000, 32'h0BAD_F00D, 4'h9);
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    n_checks++;
    if ({m_axil_awvalid, m_axil_wvalid, m_axil_awaddr, m_axil_wdata, m_axil_wstrb} !== {2'b11, 32'h0000_6000, 32'h0BAD_F00D, 4'h9}) begin
      n_fail++; $display("FAIL rmid_next_fwd: got v=%b%b addr=%h data=%h strb=%h", m_axil_awvalid, m_axil_wvalid, m_axil_awaddr, m_axil_wdata, m_axil_wstrb);
    end
    tick();
    m_axil_bvalid = 1'b1; m_axil_bresp = 2'b00;
    tick();
    m_axil_bvalid = 1'b0;
    n_checks++;
    if ({s_axil_bvalid, s_axil_bresp} !== 3'b100) begin
      n_fail++; $display("FAIL rmid_next_resp: got valid=%b resp=%0d, required 1 0", s_axil_bvalid, s_axil_bresp);
    end
    s_axil_bready = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < RN; i++) begin
      ta[i] = $urandom;
      tp[i] = 3'($urandom_range(0, 7));
      td[i] = $urandom;
      ts[i] = 4'($urandom_range(0, 15));
      tb[i] = 2'($urandom_range(0, 3));
    end
    maw_cnt = 0; mw_cnt = 0; mb_cnt = 0; abort = 1'b0;
    fork
      begin : slave_aw
        int t;
        for (int i = 0; i < RN && !abort; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          s_axil_awaddr = ta[i]; s_axil_awprot = tp[i]; s_axil_awvalid = 1'b1;
          t = 0;
          while (!s_axil_awready && t < TMO && !abort) begin tick(); t++; end
          n_checks++;
          if (t >= TMO) begin n_fail++; abort = 1'b1; $display("FAIL rnd_s_aw_timeout txn %0d: awready not seen in %0d cycles", i, TMO); end
          tick();
          s_axil_awvalid = 1'b0;
        end
      end
      begin : slave_w
        int t;
        for (int i = 0; i < RN && !abort; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          s_axil_wdata = td[i]; s_axil_wstrb = ts[i]; s_axil_wvalid = 1'b1;
          t = 0;
          while (!s_axil_wready && t < TMO && !abort) begin tick(); t++; end
          n_checks++;
          if (t >= TMO) begin n_fail++; abort = 1'b1; $display("FAIL rnd_s_w_timeout txn %0d: wready not seen in %0d cycles", i, TMO); end
          tick();
          s_axil_wvalid = 1'b0;
        end
      end
      begin : master_aw
        int t;
        for (int i = 0; i < RN && !abort; i++) begin
          t = 0;
          while (!m_axil_awvalid && t < TMO && !abort) begin tick(); t++; end
          if (abort) break;
          n_checks++;
          if (t >= TMO) begin n_fail++; abort = 1'b1; $display("FAIL rnd_m_aw_timeout txn %0d: m_awvalid not seen", i); break; end
          n_checks++;
          if ({m_axil_awaddr, m_axil_awprot} !== {ta[i], tp[i]}) begin
            n_fail++; $display("FAIL rnd_m_aw txn %0d: got addr=%h prot=%0d, required addr=%h prot=%0d", i, m_axil_awaddr, m_axil_awprot, ta[i], tp[i]);
          end
          n_checks++;
          if (mb_cnt !== i) begin
            n_fail++; $display("FAIL rnd_outstanding txn %0d: master B count %0d, required %0d", i, mb_cnt, i);
          end
          repeat ($urandom_range(0, 3)) tick();
          m_axil_awready = 1'b1;
          tick();
          m_axil_awready = 1'b0;
          maw_cnt++;
        end
      end
      begin : master_w
        int t;
        for (int i = 0; i < RN && !abort; i++) begin
          t = 0;
          while (!m_axil_wvalid && t < TMO && !abort) begin tick(); t++; end
          if (abort) break;
          n_checks++;
          if (t >= TMO) begin n_fail++; abort = 1'b1; $display("FAIL rnd_m_w_timeout txn %0d: m_wvalid not seen", i); break; end
          n_checks++;
          if ({m_axil_wdata, m_axil_wstrb} !== {td[i], ts[i]}) begin
            n_fail++; $display("FAIL rnd_m_w txn %0d: got data=%h strb=%h, required data=%h strb=%h", i, m_axil_wdata, m_axil_wstrb, td[i], ts[i]);
          end
          repeat ($urandom_range(0, 3)) tick();
          m_axil_wready = 1'b1;
          tick();
          m_axil_wready = 1'b0;
          mw_cnt++;
        end
      end
      begin : master_b
        int t;
        for (int i = 0; i < RN && !abort; i++) begin
          t = 0;
          while (!(maw_cnt > i && mw_cnt > i) && t < TMO && !abort) begin tick(); t++; end
          if (abort) break;
          repeat ($urandom_range(0, 3)) tick();
          m_axil_bresp = tb[i]; m_axil_bvalid = 1'b1;
          t = 0;
          while (!m_axil_bready && t < TMO && !abort) begin tick(); t++; end
          n_checks++;
          if (t >= TMO) begin n_fail++; abort = 1'b1; $display("FAIL rnd_m_b_timeout txn %0d: m_bready not seen", i); end
          tick();
          m_axil_bvalid = 1'b0;
          mb_cnt++;
        end
      end
      begin : slave_b
        int t;
        for (int i = 0; i < RN && !abort; i++) begin
          s_axil_bready = 1'b0;
          t = 0;
          while (!s_axil_bvalid && t < TMO && !abort) begin tick(); t++; end
          if (abort) break;
          n_checks++;
          if (t >= TMO) begin n_fail++; abort = 1'b1; $display("FAIL rnd_s_b_timeout txn %0d: s_bvalid not seen", i); break; end
          repeat ($urandom_range(0, 4)) tick();
          s_axil_bready = 1'b1;
          n_checks++;
          if (s_axil_bresp !== tb[i]) begin
            n_fail++; $display("FAIL rnd_bresp txn %0d: got %0d, required %0d", i, s_axil_bresp, tb[i]);
          end
          tick();
          s_axil_bready = 1'b0;
        end
      end
    join
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_w_first();
    test_master_skew();
    test_b_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
